// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions for the register file block.
// Contents: register/index/data widths, port counts, the register file FSM
// state type, and a helper that turns a register index into a one-hot mask.
// Index 0 maps to an empty mask because register 0 is hardwired zero.
package pipeline_pkg;

  localparam int REGISTER_COUNT = 32;
  localparam int IDX_W          = 5;
  localparam int DATA_W         = 32;
  localparam int LOAD_PORTS     = 4;
  localparam int RESERVE_PORTS  = 2;
  localparam int WRITE_PORTS    = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    CHECK = 1'b1
  } register_file_state_t;

  // One-hot mask for a register index; index 0 never owns a bit.
  function automatic logic [REGISTER_COUNT-1:0] idx_mask(input logic [IDX_W-1:0] idx);
    idx_mask = '0;
    if (idx != '0) idx_mask[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/register_file_if.sv
// Decode <-> register file bus.
// Handshake: the decode side (master) may pulse loadLatchIn for one cycle only
// while readyOut is high; the request is accepted on that edge and readyOut
// drops until loadValuesOut holds the operands for it. loadValuesOut is valid
// whenever readyOut is high. Writeback strobes are independent of the handshake
// and may be issued any cycle.
// Signals:
//   loadIndicesIn/reserveIndicesIn/loadLatchIn : request (master -> slave)
//   writeEnableIn/writeIndicesIn/writeValuesIn : writeback ports (master -> slave)
//   loadValuesOut/readyOut                     : response (slave -> master)
//   stateOut/reservedOut                       : debug visibility of FSM and scoreboard
interface register_file_if;
  import pipeline_pkg::*;

  logic [LOAD_PORTS-1:0][IDX_W-1:0]    loadIndicesIn;
  logic [RESERVE_PORTS-1:0][IDX_W-1:0] reserveIndicesIn;
  logic                                loadLatchIn;
  logic [LOAD_PORTS-1:0][DATA_W-1:0]   loadValuesOut;
  logic                                readyOut;
  logic [WRITE_PORTS-1:0]              writeEnableIn;
  logic [WRITE_PORTS-1:0][IDX_W-1:0]   writeIndicesIn;
  logic [WRITE_PORTS-1:0][DATA_W-1:0]  writeValuesIn;
  register_file_state_t                stateOut;
  logic [REGISTER_COUNT-1:0]           reservedOut;

  modport master (
    output loadIndicesIn, reserveIndicesIn, loadLatchIn,
    output writeEnableIn, writeIndicesIn, writeValuesIn,
    input  loadValuesOut, readyOut, stateOut, reservedOut
  );

  modport slave (
    input  loadIndicesIn, reserveIndicesIn, loadLatchIn,
    input  writeEnableIn, writeIndicesIn, writeValuesIn,
    output loadValuesOut, readyOut, stateOut, reservedOut
  );

endinterface

// File: rtl/register_scoreboard.sv
// Reservation bits, one per architectural register.
// Ports:
//   clk, rst             : clock, asynchronous active-high reset
//   i_set_mask           : reservations granted this cycle
//   i_clear_mask         : reservations released by this cycle's writebacks
//   o_bits               : registered reservation bits
//   o_bits_after_clear   : current bits with this cycle's clears applied,
//                          used for hazard evaluation in the same cycle
// A bit both cleared and set in one cycle ends up set (the new reservation).
module register_scoreboard
  import pipeline_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic [REGISTER_COUNT-1:0] i_set_mask,
  input  logic [REGISTER_COUNT-1:0] i_clear_mask,
  output logic [REGISTER_COUNT-1:0] o_bits,
  output logic [REGISTER_COUNT-1:0] o_bits_after_clear
);

  logic [REGISTER_COUNT-1:0] r_bits;

  assign o_bits_after_clear = r_bits & ~i_clear_mask;
  assign o_bits             = r_bits;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_bits <= '0;
    else     r_bits <= o_bits_after_clear | i_set_mask;
  end

endmodule

// File: rtl/register_file.sv
// Architectural register file with reservation scoreboard.
// Accepts a load/reserve request in IDLE, waits in CHECK until no source or
// destination index is reserved (after this cycle's writebacks), then captures
// the operands (with same-cycle writeback forwarding), reserves the
// destinations and returns to IDLE with readyOut high.
// Ports:
//   clockIn  : rising-edge clock
//   resetIn  : asynchronous active-high reset
//   bus      : request, writeback and response signals (slave side)
module register_file
  import pipeline_pkg::*;
(
  input  logic           clockIn,
  input  logic           resetIn,
  register_file_if.slave bus
);

  logic [DATA_W-1:0]                   r_regs [REGISTER_COUNT];
  register_file_state_t                r_state;
  register_file_state_t                w_state_next;
  logic [LOAD_PORTS-1:0][IDX_W-1:0]    r_load_idx;
  logic [RESERVE_PORTS-1:0][IDX_W-1:0] r_res_idx;
  logic [LOAD_PORTS-1:0][DATA_W-1:0]   r_load_values;
  logic                                r_ready;

  logic [REGISTER_COUNT-1:0]           w_clear_mask;
  logic [REGISTER_COUNT-1:0]           w_set_mask;
  logic [REGISTER_COUNT-1:0]           w_bits;
  logic [REGISTER_COUNT-1:0]           w_bits_after_clear;
  logic                                w_hazard;
  logic                                w_commit;
  logic [LOAD_PORTS-1:0][DATA_W-1:0]   w_operands;

  register_scoreboard u_scoreboard (
    .clk                (clockIn),
    .rst                (resetIn),
    .i_set_mask         (w_set_mask),
    .i_clear_mask       (w_clear_mask),
    .o_bits             (w_bits),
    .o_bits_after_clear (w_bits_after_clear)
  );

  // Writeback clears, hazard detection and forwarded operand values.
  always_comb begin
    w_clear_mask = '0;
    w_hazard     = 1'b0;
    w_operands   = '0;
    for (int p = 0; p < WRITE_PORTS; p++) begin
      if (bus.writeEnableIn[p]) w_clear_mask |= idx_mask(bus.writeIndicesIn[p]);
    end
    // idx_mask of index 0 is empty, so index 0 never raises a hazard.
    for (int l = 0; l < LOAD_PORTS; l++) begin
      if (|(idx_mask(r_load_idx[l]) & w_bits_after_clear)) w_hazard = 1'b1;
    end
    for (int r = 0; r < RESERVE_PORTS; r++) begin
      if (|(idx_mask(r_res_idx[r]) & w_bits_after_clear)) w_hazard = 1'b1;
    end
    // Later ports override earlier ones, so port 1 wins a same-index collision.
    for (int l = 0; l < LOAD_PORTS; l++) begin
      w_operands[l] = r_regs[r_load_idx[l]];
      for (int p = 0; p < WRITE_PORTS; p++) begin
        if (bus.writeEnableIn[p] && (bus.writeIndicesIn[p] == r_load_idx[l])) begin
          w_operands[l] = bus.writeValuesIn[p];
        end
      end
      if (r_load_idx[l] == '0) w_operands[l] = '0;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    w_commit     = 1'b0;
    w_set_mask   = '0;
    case (r_state)
      IDLE: begin
        if (bus.loadLatchIn) w_state_next = CHECK;
      end
      CHECK: begin
        if (!w_hazard) begin
          w_commit     = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
    if (w_commit) begin
      for (int r = 0; r < RESERVE_PORTS; r++) w_set_mask |= idx_mask(r_res_idx[r]);
    end
  end

  always_ff @(posedge clockIn or posedge resetIn) begin
    if (resetIn) begin
      r_state       <= IDLE;
      r_load_idx    <= '0;
      r_res_idx     <= '0;
      r_load_values <= '0;
      r_ready       <= 1'b1;
    end else begin
      r_state <= w_state_next;
      if ((r_state == IDLE) && bus.loadLatchIn) begin
        r_load_idx <= bus.loadIndicesIn;
        r_res_idx  <= bus.reserveIndicesIn;
        r_ready    <= 1'b0;
      end
      if (w_commit) begin
        r_load_values <= w_operands;
        r_ready       <= 1'b1;
      end
    end
  end

  // Register storage; writes to index 0 are dropped so it always reads zero.
  always_ff @(posedge clockIn or posedge resetIn) begin
    if (resetIn) begin
      for (int i = 0; i < REGISTER_COUNT; i++) r_regs[i] <= '0;
    end else begin
      for (int p = 0; p < WRITE_PORTS; p++) begin
        if (bus.writeEnableIn[p] && (bus.writeIndicesIn[p] != '0)) begin
          r_regs[bus.writeIndicesIn[p]] <= bus.writeValuesIn[p];
        end
      end
    end
  end

  assign bus.loadValuesOut = r_load_values;
  assign bus.readyOut      = r_ready;
  assign bus.stateOut      = r_state;
  assign bus.reservedOut   = w_bits;

endmodule

// File: tb/tb_register_file.sv
// Bench for register_file: directed scenarios followed by random traffic,
// every cycle compared against a behavioural model of the register file.
module tb_register_file;
  import pipeline_pkg::*;

  logic clockIn = 1'b0;
  logic resetIn;
  register_file_if bus ();

  register_file dut (
    .clockIn (clockIn),
    .resetIn (resetIn),
    .bus     (bus)
  );

  // Clock / reset
  always #5 clockIn = ~clockIn;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model state
  logic [31:0] m_regs [32];
  logic        m_resv [32];
  logic        m_busy;
  logic [4:0]  m_src  [4];
  logic [4:0]  m_res  [2];
  logic [31:0] m_vals [4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_resv_vec();
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = m_resv[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = '0;
      m_resv[i] = 1'b0;
    end
    for (int l = 0; l < 4; l++) begin
      m_vals[l] = '0;
      m_src[l]  = '0;
    end
    m_res[0] = '0;
    m_res[1] = '0;
    m_busy   = 1'b0;
  endtask

  // Operand value as decode would see it this cycle: zero register, stored
  // value, or the writeback being issued right now (port 1 beats port 0).
  function automatic logic [31:0] m_operand(input logic [4:0] idx);
    logic [31:0] v;
    if (idx == 0) return 32'h0;
    v = m_regs[idx];
    for (int p = 0; p < 2; p++)
      if (bus.writeEnableIn[p] && bus.writeIndicesIn[p] == idx) v = bus.writeValuesIn[p];
    return v;
  endfunction

  // Advance the model over one clock edge using the inputs currently driven.
  task automatic model_edge();
    logic pend [32];
    logic hazard;
    for (int i = 0; i < 32; i++) pend[i] = m_resv[i];
    for (int p = 0; p < 2; p++)
      if (bus.writeEnableIn[p] && bus.writeIndicesIn[p] != 0) pend[bus.writeIndicesIn[p]] = 1'b0;
    if (m_busy) begin
      hazard = 1'b0;
      for (int l = 0; l < 4; l++) if (m_src[l] != 0 && pend[m_src[l]]) hazard = 1'b1;
      for (int r = 0; r < 2; r++) if (m_res[r] != 0 && pend[m_res[r]]) hazard = 1'b1;
      if (!hazard) begin
        for (int l = 0; l < 4; l++) m_vals[l] = m_operand(m_src[l]);
        for (int r = 0; r < 2; r++) if (m_res[r] != 0) pend[m_res[r]] = 1'b1;
        m_busy = 1'b0;
      end
    end else if (bus.loadLatchIn) begin
      for (int l = 0; l < 4; l++) m_src[l] = bus.loadIndicesIn[l];
      for (int r = 0; r < 2; r++) m_res[r] = bus.reserveIndicesIn[r];
      m_busy = 1'b1;
    end
    for (int p = 0; p < 2; p++)
      if (bus.writeEnableIn[p] && bus.writeIndicesIn[p] != 0)
        m_regs[bus.writeIndicesIn[p]] = bus.writeValuesIn[p];
    for (int i = 0; i < 32; i++) m_resv[i] = pend[i];
  endtask

  // Driver tasks
  task automatic drive_quiet();
    bus.loadIndicesIn    = '0;
    bus.reserveIndicesIn = '0;
    bus.loadLatchIn      = 1'b0;
    bus.writeEnableIn    = '0;
    bus.writeIndicesIn   = '0;
    bus.writeValuesIn    = '0;
  endtask

  task automatic latch(input logic [4:0] s0, s1, s2, s3, r0, r1);
    bus.loadIndicesIn[0]    = s0;
    bus.loadIndicesIn[1]    = s1;
    bus.loadIndicesIn[2]    = s2;
    bus.loadIndicesIn[3]    = s3;
    bus.reserveIndicesIn[0] = r0;
    bus.reserveIndicesIn[1] = r1;
    bus.loadLatchIn         = 1'b1;
  endtask

  task automatic wr(input int p, input logic [4:0] idx, input logic [31:0] val);
    bus.writeEnableIn[p]  = 1'b1;
    bus.writeIndicesIn[p] = idx;
    bus.writeValuesIn[p]  = val;
  endtask

  // One clock: protocol check, model update, edge, scoreboard compare.
  task automatic step();
    if (bus.loadLatchIn) chk("latch_while_busy", 32'(bus.readyOut), 32'h1);
    model_edge();
    @(posedge clockIn);
    #1;
    chk("ready", 32'(bus.readyOut), 32'(!m_busy));
    chk("state", 32'(bus.stateOut), m_busy ? 32'(CHECK) : 32'(IDLE));
    chk("resv_bits", bus.reservedOut, m_resv_vec());
    for (int l = 0; l < 4; l++) chk($sformatf("value%0d", l), bus.loadValuesOut[l], m_vals[l]);
    bus.loadLatchIn   = 1'b0;
    bus.writeEnableIn = '0;
  endtask

  initial begin
    drive_quiet();
    model_reset();
    resetIn = 1'b1;
    repeat (2) @(posedge clockIn);
    @(negedge clockIn);
    resetIn = 1'b0;
    chk("reset_ready", 32'(bus.readyOut), 32'h1);
    chk("reset_bits", bus.reservedOut, 32'h0);
    chk("reset_value0", bus.loadValuesOut[0], 32'h0);

    // Basic load after preload through writeback
    wr(0, 5'd1, 32'd10);
    wr(1, 5'd2, 32'd20);
    step();
    wr(0, 5'd3, 32'd30);
    step();
    latch(5'd1, 5'd2, 5'd3, 5'd0, 5'd0, 5'd0);
    step();
    chk("basic_not_ready_1edge", 32'(bus.readyOut), 32'h0);
    step();
    chk("basic_ready_2edges", 32'(bus.readyOut), 32'h1);
    chk("basic_v0", bus.loadValuesOut[0], 32'd10);
    chk("basic_v1", bus.loadValuesOut[1], 32'd20);
    chk("basic_v2", bus.loadValuesOut[2], 32'd30);
    chk("basic_v3", bus.loadValuesOut[3], 32'd0);

    // RAW stall resolved by a forwarded writeback
    latch(5'd0, 5'd0, 5'd0, 5'd0, 5'd5, 5'd0);
    step();
    step();
    chk("raw_bit5_set", 32'(bus.reservedOut[5]), 32'h1);
    latch(5'd5, 5'd1, 5'd0, 5'd0, 5'd0, 5'd0);
    repeat (4) step();
    chk("raw_stalled", 32'(bus.readyOut), 32'h0);
    wr(0, 5'd5, 32'hDEAD);
    step();
    chk("raw_ready", 32'(bus.readyOut), 32'h1);
    chk("raw_forward", bus.loadValuesOut[0], 32'hDEAD);
    chk("raw_bit5_clear", 32'(bus.reservedOut[5]), 32'h0);

    // WAW stall
    latch(5'd0, 5'd0, 5'd0, 5'd0, 5'd7, 5'd0);
    step();
    step();
    latch(5'd0, 5'd0, 5'd0, 5'd0, 5'd7, 5'd0);
    repeat (3) step();
    chk("waw_stalled", 32'(bus.readyOut), 32'h0);
    wr(1, 5'd7, 32'h77);
    step();
    chk("waw_ready", 32'(bus.readyOut), 32'h1);
    chk("waw_bit7_reset", 32'(bus.reservedOut[7]), 32'h1);

    // Dual writeback collision: port 1 wins
    wr(0, 5'd9, 32'h1111);
    wr(1, 5'd9, 32'h2222);
    step();
    latch(5'd9, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0);
    step();
    step();
    chk("collide_value", bus.loadValuesOut[0], 32'h2222);
    chk("collide_bit9", 32'(bus.reservedOut[9]), 32'h0);

    // Zero register
    wr(0, 5'd0, 32'hFFFF);
    step();
    latch(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0);
    step();
    step();
    chk("zero_ready", 32'(bus.readyOut), 32'h1);
    for (int l = 0; l < 4; l++) chk($sformatf("zero_v%0d", l), bus.loadValuesOut[l], 32'h0);
    chk("zero_bit0", 32'(bus.reservedOut[0]), 32'h0);

    // Reset while stalled in CHECK
    latch(5'd0, 5'd0, 5'd0, 5'd0, 5'd4, 5'd0);
    step();
    step();
    latch(5'd4, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0);
    step();
    step();
    chk("rst_pre_stalled", 32'(bus.readyOut), 32'h0);
    #2 resetIn = 1'b1;
    #1;
    chk("rst_async_ready", 32'(bus.readyOut), 32'h1);
    chk("rst_async_bits", bus.reservedOut, 32'h0);
    chk("rst_async_value", bus.loadValuesOut[0], 32'h0);
    model_reset();
    #2 resetIn = 1'b0;
    latch(5'd4, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0);
    step();
    step();
    chk("rst_relatch_ready", 32'(bus.readyOut), 32'h1);
    chk("rst_relatch_value", bus.loadValuesOut[0], 32'h0);

    // Random traffic over a small index range to provoke hazards
    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < 2; p++)
        if ($urandom_range(0, 1) == 1) wr(p, 5'($urandom_range(0, 7)), $urandom);
      if (!m_busy && $urandom_range(0, 2) == 0)
        latch(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
              5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
              5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
